// File: rtl/spi_pkg.sv
// Shared definitions for the SPI bring-up master: FSM state encoding,
// transfer-length decode and button synchronizer depth.
// No ports; imported by spi_master_gpio and sync_edge.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Flip-flop stages between a raw board pin and the core clock domain.
  localparam int SYNC_STAGES = 2;

  // transaction_length code -> number of bits (8, 16, 24, 32).
  function automatic logic [5:0] len_to_bits(input logic [1:0] len);
    return ({4'b0000, len} + 6'd1) << 3;
  endfunction

endpackage

// File: rtl/spi_master_gpio_sync_edge.sv
// sync_edge: synchronizes a raw button/pin and emits a one-cycle pulse on its rising edge.
// Latency: pulse is registered, high 3 clk after the pin edge (2 sync stages + edge register).
// No backpressure: a held level produces exactly one pulse; release and press again for another.
// Ports: i_clk, i_rst (async, active high), i_async (raw pin), o_rise (one-cycle pulse).
module sync_edge
  import spi_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
      r_rise <= r_sync[STAGES-1] & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/spi_master_gpio.sv
// spi_master_gpio: button-triggered SPI master, one CS-framed 8/16/24/32-bit MSB-first transfer.
// Latency: CS low for (2n+2)*CLK_DIV clk, then CLK_DIV clk gap; done pulses as rx_data updates.
// No backpressure: start requests arriving while busy are dropped, never queued.
// Ports: clk, rst; start (raw button), tx_data, transaction_length, CPOL, CPHA,
//        display_high_bits, MISO in; MOSI, SPI_SCLK, CS (active low), busy, done,
//        rx_data (right-aligned), led (16-bit page of rx_data) out.
module spi_master_gpio
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] tx_data,
  input  logic [1:0]  transaction_length,
  input  logic        CPOL,
  input  logic        CPHA,
  input  logic        display_high_bits,
  input  logic        MISO,
  output logic        MOSI,
  output logic        SPI_SCLK,
  output logic        CS,
  output logic        busy,
  output logic        done,
  output logic [31:0] rx_data,
  output logic [15:0] led
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic [31:0]      r_tx;
  logic [31:0]      r_rx;
  logic [31:0]      r_rx_data;
  logic [5:0]       r_n;
  logic [5:0]       r_bit;
  logic             r_cpol;
  logic             r_cpha;
  logic             r_sclk;
  logic             r_mosi;
  logic             r_cs;
  logic             r_done;

  logic             w_start_rise;
  logic             w_tick;
  logic             w_leading;
  logic             w_sample;
  logic             w_advance;
  logic             w_last_edge;
  logic [5:0]       w_n;
  logic [31:0]      w_tx_aligned;

  sync_edge #(.STAGES(SYNC_STAGES)) u_start_sync (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_async (start),
    .o_rise  (w_start_rise)
  );

  // Decode of the live inputs, only consumed on the accept cycle. The word is
  // left-aligned so the outgoing bit is always r_tx[31] regardless of length.
  always_comb begin
    w_n          = len_to_bits(transaction_length);
    w_tx_aligned = tx_data << (6'd32 - w_n);
  end

  // SCLK edge classification. An edge happens on w_tick in SHIFT; it is a
  // leading edge when SCLK currently sits at its idle level.
  always_comb begin
    w_tick      = (r_div == DIV_LAST);
    w_leading   = (r_sclk == r_cpol);
    w_sample    = 1'b0;
    w_advance   = 1'b0;
    w_last_edge = 1'b0;
    if (r_state == ST_SHIFT && w_tick) begin
      // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
      w_sample  = (w_leading != r_cpha);
      // The transfer always ends on a trailing edge: with CPHA=0 all n bits
      // were already sampled, with CPHA=1 this edge samples the last bit.
      if (!w_leading) begin
        w_last_edge = r_cpha ? (r_bit == r_n - 6'd1) : (r_bit == r_n);
      end
      // CPHA=1 presents a new bit on every leading edge; CPHA=0 already put
      // bit n-1 out in SETUP and advances on trailing edges except the last.
      w_advance = r_cpha ? w_leading : (!w_leading && !w_last_edge);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start_rise) w_state_nxt = ST_SETUP;
      ST_SETUP: if (w_tick)       w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last_edge)  w_state_nxt = ST_HOLD;
      ST_HOLD:  if (w_tick)       w_state_nxt = ST_GAP;
      ST_GAP:   if (w_tick)       w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Half-period counter; held at zero in IDLE so SETUP starts a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
    end else if (r_state == ST_IDLE || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_n       <= 6'd8;
      r_bit     <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sclk <= CPOL;
          if (w_start_rise) begin
            r_n    <= w_n;
            r_cpol <= CPOL;
            r_cpha <= CPHA;
            r_cs   <= 1'b0;
            r_bit  <= '0;
            r_rx   <= '0;
            if (CPHA) begin
              r_tx <= w_tx_aligned;
            end else begin
              r_mosi <= w_tx_aligned[31];
              r_tx   <= {w_tx_aligned[30:0], 1'b0};
            end
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            r_sclk <= ~r_sclk;
          end
          if (w_sample) begin
            r_rx  <= {r_rx[30:0], MISO};
            r_bit <= r_bit + 6'd1;
          end
          if (w_advance) begin
            r_mosi <= r_tx[31];
            r_tx   <= {r_tx[30:0], 1'b0};
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_cs      <= 1'b1;
            r_rx_data <= r_rx;
            r_done    <= 1'b1;
            r_mosi    <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign MOSI     = r_mosi;
  assign SPI_SCLK = r_sclk;
  assign CS       = r_cs;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign rx_data  = r_rx_data;
  assign led      = display_high_bits ? r_rx_data[31:16] : r_rx_data[15:0];

endmodule

// File: doc/spi_master_gpio.md
# spi_master_gpio

Board-level SPI master for on-FPGA bring-up of the SPI slave test tops. It takes a 32-bit word from switches, a transfer length and the CPOL/CPHA mode. On a button press it runs one chip-select-framed transaction of 8/16/24/32 bits, MSB first, and shows the word received on MISO on the LEDs. It drives the slave boards over a Pmod header and replaces the external logic-analyser master used today.

## Interface
- CLK_DIV, 4: SCLK half-period in clk cycles; legal range ≥2.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  raw push-button; synchronized internally; a rising edge requests a transaction.
- tx_data  in  32  word to send; the low n bits are used, n = 8·(transaction_length+1).
- transaction_length  in  2  00=8, 01=16, 10=24, 11=32 bits.
- CPOL  in  1  SCLK idle level.
- CPHA  in  1  0: sample on leading edge; 1: sample on trailing edge.
- display_high_bits  in  1  LED page select.
- MISO  in  1  slave data in.
- MOSI  out  1  master data out.
- SPI_SCLK  out  1  serial clock.
- CS  out  1  chip select, active low.
- busy  out  1  high from CS fall through the end of GAP.
- done  out  1  one-cycle pulse when the transaction completes.
- rx_data  out  32  last received word, right-aligned, upper bits zero.
- led  out  16  rx_data[31:16] if display_high_bits=1, else rx_data[15:0].

## Operation
- Reset values: CS=1, SPI_SCLK=0, MOSI=0, busy=0, done=0, rx_data=0, state IDLE. In IDLE, SPI_SCLK follows CPOL from the first cycle after reset.
- start passes a 2-FF synchronizer plus rising-edge detect, so a request appears 3 clk after the pin edge. Requests outside IDLE are dropped, with no queueing. A held button gives exactly one transaction.
- On accept, tx_data, transaction_length, CPOL and CPHA are latched. Input changes mid-transaction have no effect.
- States:
  - IDLE → SETUP on accepted start.
  - SETUP → SHIFT after CLK_DIV cycles.
  - SHIFT → HOLD after 2n SCLK edges.
  - HOLD → GAP after CLK_DIV cycles.
  - GAP → IDLE after CLK_DIV cycles.
- SETUP: CS=0. With CPHA=0, MOSI = bit n-1 from the first SETUP cycle.
- SHIFT: SPI_SCLK toggles every CLK_DIV cycles.
  - CPHA=0: MISO is sampled on leading edges. MOSI advances to the next bit on trailing edges, except after the final edge.
  - CPHA=1: MOSI advances on leading edges (first leading edge presents bit n-1). MISO is sampled on trailing edges.
  - A bit counter counts sampled bits 0..n-1.
- HOLD: SCLK is at the CPOL level and CS stays 0.
- GAP entry, same cycle: CS=1, rx_data ← shift register (zero-extended), done=1. MOSI returns to 0 at GAP entry.
- Asynchronous reset mid-transaction: CS rises and SCLK/MOSI clear immediately. rx_data clears and the partial word is discarded.

## Timing
- CS low duration = (2n+2)·CLK_DIV clk cycles. Examples at CLK_DIV=4: 72 for n=8, 264 for n=32.
- First SCLK edge comes CLK_DIV cycles after CS falls. Last SCLK edge comes CLK_DIV cycles before CS rises.
- Minimum accepted start-to-start spacing = (2n+3)·CLK_DIV + 1 cycles.
- done and the rx_data update fall in the same cycle. led follows rx_data combinationally.

## Structure
- Shared package spi_pkg:
  - state encoding IDLE/SETUP/SHIFT/HOLD/GAP;
  - length decode function returning n (8/16/24/32);
  - constant for the 2-FF synchronizer depth.
- Sub-module sync_edge: synchronizer plus rising-edge detect for start. It is reusable for the other board buttons.
- The FSM, SCLK divider counter, 32-bit shift-out and shift-in registers and bit counter live in the top.

## Test plan
- Mode 0, len=00, tx_data=0x000000A5, MOSI looped to MISO:
  - rx_data=0x000000A5 and one done pulse;
  - exactly 8 SCLK rising edges;
  - CS low for 72 cycles at CLK_DIV=4.
- Mode 3, len=11, behavioural slave returns 0xDEADBEEF:
  - rx_data=0xDEADBEEF;
  - SCLK idles high before and after;
  - led=0xBEEF, then 0xDEAD when display_high_bits=1.
- Mode 1, len=01, tx=0x1234, loopback:
  - MOSI changes only on SCLK rising edges;
  - rx_data=0x00001234.
- Second start edge 10 cycles into a transaction, then start held high for 1000 cycles:
  - exactly one transaction;
  - tx_data changed mid-transfer does not alter MOSI.
- rst asserted mid-SHIFT:
  - CS=1, SPI_SCLK=0, rx_data=0 with no clock edge;
  - after release, a new start completes normally.
